fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have ports `clk` (input, 1 bit), the single clock. All state changes on its rising edge.
REQ-003 SHALL have ports `rst` (input, 1 bit): asynchronous, active-low reset.
REQ-004 SHALL have ports `stall` (input, 1 bit): decode cannot accept; hold instr/pc/valid.
REQ-005 SHALL have ports `flush` (input, 1 bit): taken branch; redirect fetch to `branch_target`.
REQ-006 SHALL have ports `branch_target` (input, 16 bits): redirect address, sampled when `flush`=1.
REQ-007 SHALL have ports `imem_req` (output, 1 bit): instruction memory request.
REQ-008 SHALL have ports `imem_addr` (output, 16 bits): byte address of the requested instruction.
REQ-009 SHALL have ports `imem_rdata` (input, 16 bits): returned instruction word.
REQ-010 SHALL have ports `imem_valid` (input, 1 bit): `imem_rdata` is valid this cycle; arrives 1 or more cycles after the request.
REQ-011 SHALL have ports `instr` (output, 16 bits): registered instruction to decode.
REQ-012 SHALL have ports `pc` (output, 16 bits): registered address of `instr` plus 2, used as the branch base.
REQ-013 SHALL have ports `valid` (output, 1 bit): `instr`/`pc` hold a real instruction.

Function
REQ-014 SHALL implement states FETCH, HOLD, DISCARD and HALT, with internal registers pc_reg and a one-entry buffer.
REQ-015 SHALL, in FETCH, drive `imem_req`=1 and `imem_addr`=pc_reg, with both held stable until `imem_valid`.
REQ-016 SHALL, in FETCH on `imem_valid`=1 with `stall`=0 and `flush`=0, on the next edge set `instr`=`imem_rdata`, `pc`=pc_reg+2, `valid`=1 and pc_reg=pc_reg+2, giving one instruction per cycle with single-cycle memory.
REQ-017 SHALL, in FETCH with `imem_valid`=0, `stall`=0 and `flush`=0, set `valid`=0 and `instr`=16'h0000 (bubble).
REQ-018 SHALL, whenever `stall`=1 and `flush`=0, hold `instr`, `pc` and `valid` unchanged.
REQ-019 SHALL, on `imem_valid`=1 with `stall`=1, capture rdata into the buffer, advance pc_reg by 2 and enter HOLD.
REQ-020 SHALL drive `imem_req`=0 in HOLD.
REQ-021 SHALL, in HOLD when `stall`=0, move the buffer to the outputs with `valid`=1 and return to FETCH.
REQ-022 SHALL give `flush` priority over `stall` and all other inputs.
REQ-023 SHALL, on `flush`, set pc_reg=`branch_target`, `valid`=0 and `instr`=16'h0000, and discard the buffer.
REQ-024 SHALL, on `flush` while a request is outstanding (FETCH, `imem_valid`=0), enter DISCARD.
REQ-025 SHALL hold the old address in DISCARD until `imem_valid`, drop that word, then enter FETCH at the new pc_reg.
REQ-026 SHALL, on `flush` coinciding with `imem_valid`, drop the word and enter FETCH directly.
REQ-027 SHALL compute pc_reg+2 modulo 2^16, so 16'hFFFE wraps to 16'h0000.
REQ-028 SHALL keep `branch_target` bit 0 as given, with no alignment correction.

Reset
REQ-029 SHALL, while `rst`=0, asynchronously set state=FETCH, pc_reg=RESET_PC, `instr`=16'h0000, `pc`=16'h0000, `valid`=0, buffer empty and `imem_req`=0.
REQ-030 SHALL assert `imem_req` in the first cycle after `rst` deasserts.
REQ-031 SHALL abandon any in-flight memory response on reset mid-operation, with no discard tracking across reset.

Configuration
REQ-032 SHALL, with FETCH_HALT_EN defined, treat a delivered word with opcode bits [15:12]=4'hF as HLT.
REQ-033 SHALL, with FETCH_HALT_EN defined, deliver that HLT word normally, then enter HALT with `imem_req`=0 and pc_reg frozen.
REQ-034 SHALL, with FETCH_HALT_EN defined, leave HALT only on `flush` or `rst`, with outputs otherwise in bubble.
REQ-035 SHALL, without FETCH_HALT_EN, have no HALT state and treat opcode 4'hF as an ordinary instruction.

Structure
REQ-036 SHALL take the state enum, OP_HLT (4'hF), NOP_INSTR (16'h0000) and the PC increment (2) from shared package cpu_pkg.
REQ-037 SHALL implement the registered outputs (`instr`, `pc`, `valid`) in one sub-module, if_id_reg, with hold and clear controls.

Verification
REQ-038 SHALL cover: reset with RESET_PC=16'h0000 and 1-cycle memory returning 16'h1234, 16'h5678 -> `instr`=16'h1234 with `pc`=16'h0002, then 16'h5678 with `pc`=16'h0004, `valid`=1 both cycles.
REQ-039 SHALL cover: 3-cycle memory latency -> `imem_addr` stable 3 cycles, `valid`=0 for 2 cycles, then `valid`=1.
REQ-040 SHALL cover: `stall`=1 for 4 cycles while `imem_valid` arrives -> outputs unchanged, `imem_req`=0 in HOLD, buffered word delivered on the first cycle after `stall` drops.
REQ-041 SHALL cover: `flush` with `branch_target`=16'h0040 during an outstanding request -> late word dropped, next `imem_addr`=16'h0040, first delivered `pc`=16'h0042.
REQ-042 SHALL cover: `flush` and `stall` together -> `valid`=0 next cycle.
REQ-043 SHALL cover: pc_reg=16'hFFFE -> delivered `pc`=16'h0000.
REQ-044 SHALL cover (FETCH_HALT_EN defined): word 16'hF000 -> delivered, then `imem_req`=0 and `valid`=0 until `flush`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants: FSM state encoding, HLT opcode, NOP word and PC step.
package cpu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StFetch   = 2'd0;
  localparam state_t StHold    = 2'd1;
  localparam state_t StDiscard = 2'd2;
  localparam state_t StHalt    = 2'd3;

  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'd2;

  // True when the word's opcode field marks a halt instruction.
  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register: clear beats hold, hold beats load, otherwise a bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [15:0] i_instr,
  input  logic [15:0] i_pc,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid
);

  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;

  // Register update; pc is left alone on clear/bubble since it is meaningless without valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 16'h0000;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with one-entry stall buffer and branch redirect.
// Optional HLT support is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [15:0]        branch_target,
  fetch_unit_if.master       imem,
  output logic [15:0]        instr,
  output logic [15:0]        pc,
  output logic               valid
);

  state_t      r_state, w_state_d;
  logic [15:0] r_pc_reg, w_pc_d;
  logic [15:0] r_buf, w_buf_d;
  // Address still owed a response after a flush; replayed while discarding.
  logic [15:0] r_addr, w_addr_d;
  logic [15:0] w_pc_inc;
  logic        w_clear, w_hold, w_load;
  logic [15:0] w_load_instr, w_load_pc;

  assign w_pc_inc = r_pc_reg + PC_INC;

  // Bus outputs; req tied low while reset is asserted.
  always_comb begin
    imem.imem_req  = rst && ((r_state == StFetch) || (r_state == StDiscard));
    imem.imem_addr = (r_state == StDiscard) ? r_addr : r_pc_reg;
  end

  // Next-state, pc_reg/buffer update and pipeline-register control.
  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc_reg;
    w_buf_d      = r_buf;
    w_addr_d     = r_addr;
    w_clear      = 1'b0;
    w_hold       = 1'b0;
    w_load       = 1'b0;
    w_load_instr = r_buf;
    w_load_pc    = r_pc_reg;
    if (flush) begin
      w_clear = 1'b1;
      w_pc_d  = branch_target;
    end
    case (r_state)
      StFetch: begin
        if (flush) begin
          if (!imem.imem_valid) begin
            w_state_d = StDiscard;
            w_addr_d  = r_pc_reg;
          end
        end else if (imem.imem_valid) begin
          w_pc_d = w_pc_inc;
          if (stall) begin
            w_hold    = 1'b1;
            w_buf_d   = imem.imem_rdata;
            w_state_d = StHold;
          end else begin
            w_load       = 1'b1;
            w_load_instr = imem.imem_rdata;
            w_load_pc    = w_pc_inc;
`ifdef FETCH_HALT_EN
            if (is_hlt(imem.imem_rdata)) w_state_d = StHalt;
`endif
          end
        end else begin
          w_hold = stall;
        end
      end
      StHold: begin
        if (flush) begin
          w_state_d = StFetch;
        end else if (stall) begin
          w_hold = 1'b1;
        end else begin
          // pc_reg already advanced past the buffered word when it was captured.
          w_load    = 1'b1;
          w_state_d = StFetch;
`ifdef FETCH_HALT_EN
          if (is_hlt(r_buf)) w_state_d = StHalt;
`endif
        end
      end
      StDiscard: begin
        if (imem.imem_valid) w_state_d = StFetch;
        if (!flush) w_hold = stall;
      end
`ifdef FETCH_HALT_EN
      StHalt: begin
        if (flush) w_state_d = StFetch;
        else       w_hold    = stall;
      end
`endif
      default: w_state_d = StFetch;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StFetch;
      r_pc_reg <= RESET_PC;
      r_buf    <= NOP_INSTR;
      r_addr   <= RESET_PC;
    end else begin
      r_state  <= w_state_d;
      r_pc_reg <= w_pc_d;
      r_buf    <= w_buf_d;
      r_addr   <= w_addr_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_hold  (w_hold),
    .i_load  (w_load),
    .i_instr (w_load_instr),
    .i_pc    (w_load_pc),
    .o_instr (instr),
    .o_pc    (pc),
    .o_valid (valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a latency-programmable instruction memory.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] instr, pc;
  logic        valid;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (bus),
    .instr         (instr),
    .pc            (pc),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: word array, latency fixed (fixed_lat>0) or random 1..3 per request.
  logic [15:0] mem [0:32767];
  int fixed_lat = 1;
  int cnt = 0;
  int lat = 1;

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
  end

  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0;
      bus.imem_valid = 1'b0;
    end else begin
      if (bus.imem_valid) cnt = 0;
      if (bus.imem_req) begin
        if (cnt == 0) lat = (fixed_lat == 0) ? int'($urandom_range(1, 3)) : fixed_lat;
        cnt++;
        bus.imem_valid = (cnt >= lat);
        bus.imem_rdata = bus.imem_valid ? mem[bus.imem_addr[15:1]] : 16'($urandom);
      end else begin
        cnt = 0;
        bus.imem_valid = 1'b0;
      end
    end
  end

  // Bus values seen just before the most recent rising edge.
  logic        p_req, p_mvalid;
  logic [15:0] p_addr;

  task automatic tick(input logic s, input logic f, input logic [15:0] t);
    @(negedge clk);
    stall = s;
    flush = f;
    branch_target = t;
    #1;
    p_req    = bus.imem_req;
    p_addr   = bus.imem_addr;
    p_mvalid = bus.imem_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #3;
    checks++;
    if (bus.imem_req !== 1'b0 || valid !== 1'b0 || instr !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state req=%b valid=%b instr=%h pc=%h want 0/0/0000/0000",
               bus.imem_req, valid, instr, pc);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_first_req req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_basic();
    fixed_lat = 1;
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    do_reset();
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (instr !== 16'h1234 || pc !== 16'h0002 || valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_first instr=%h pc=%h valid=%b want 1234/0002/1", instr, pc, valid);
    end
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (instr !== 16'h5678 || pc !== 16'h0004 || valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_second instr=%h pc=%h valid=%b want 5678/0004/1", instr, pc, valid);
    end
  endtask

  task automatic test_latency();
    fixed_lat = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      checks++;
      if (p_req !== 1'b1 || p_addr !== 16'h0000) begin
        errors++;
        $display("FAIL latency_addr cyc=%0d req=%b addr=%h want 1/0000", i, p_req, p_addr);
      end
      checks++;
      if (valid !== (i == 2)) begin
        errors++;
        $display("FAIL latency_valid cyc=%0d valid=%b want %b", i, valid, (i == 2));
      end
    end
    checks++;
    if (instr !== mem[0] || pc !== 16'h0002) begin
      errors++;
      $display("FAIL latency_data instr=%h pc=%h want %h/0002", instr, pc, mem[0]);
    end
  endtask

  task automatic test_stall();
    fixed_lat = 1;
    do_reset();
    tick(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 16'h0);
      checks++;
      if (instr !== mem[0] || pc !== 16'h0002 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d instr=%h pc=%h valid=%b want %h/0002/1",
                 i, instr, pc, valid, mem[0]);
      end
      if (i > 0) begin
        checks++;
        if (p_req !== 1'b0) begin
          errors++;
          $display("FAIL stall_req_off cyc=%0d req=%b want 0", i, p_req);
        end
      end
    end
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (instr !== mem[1] || pc !== 16'h0004 || valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release instr=%h pc=%h valid=%b want %h/0004/1",
               instr, pc, valid, mem[1]);
    end
  endtask

  task automatic test_flush();
    bit seen_new = 0;
    bit done = 0;
    fixed_lat = 3;
    mem[16'h0020] = 16'h0BCD;
    do_reset();
    tick(1'b0, 1'b1, 16'h0040);
    checks++;
    if (valid !== 1'b0 || instr !== 16'h0000) begin
      errors++;
      $display("FAIL flush_clear valid=%b instr=%h want 0/0000", valid, instr);
    end
    for (int i = 0; i < 12 && !done; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      if (p_req && p_addr == 16'h0040) seen_new = 1;
      checks++;
      if (p_req && p_addr !== 16'h0000 && p_addr !== 16'h0040) begin
        errors++;
        $display("FAIL flush_addr cyc=%0d addr=%h want 0000 or 0040", i, p_addr);
      end
      if (valid) begin
        done = 1;
        checks++;
        if (!seen_new || pc !== 16'h0042 || instr !== 16'h0BCD) begin
          errors++;
          $display("FAIL flush_redirect seen=%b pc=%h instr=%h want 1/0042/0bcd",
                   seen_new, pc, instr);
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL flush_timeout valid=%b want a delivery within 12 cycles", valid);
    end
  endtask

  task automatic test_flush_stall();
    fixed_lat = 1;
    mem[16'h0040] = 16'h4321;
    do_reset();
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h0080);
    checks++;
    if (valid !== 1'b0 || instr !== 16'h0000) begin
      errors++;
      $display("FAIL flush_stall valid=%b instr=%h want 0/0000", valid, instr);
    end
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (valid !== 1'b1 || pc !== 16'h0082 || instr !== 16'h4321) begin
      errors++;
      $display("FAIL flush_stall_next valid=%b pc=%h instr=%h want 1/0082/4321", valid, pc, instr);
    end
  endtask

  task automatic test_wrap();
    fixed_lat = 1;
    mem[16'h7FFF] = 16'h2EEE;
    do_reset();
    tick(1'b0, 1'b1, 16'hFFFE);
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (valid !== 1'b1 || pc !== 16'h0000 || instr !== 16'h2EEE) begin
      errors++;
      $display("FAIL wrap_pc valid=%b pc=%h instr=%h want 1/0000/2eee", valid, pc, instr);
    end
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (valid !== 1'b1 || pc !== 16'h0002 || instr !== mem[0]) begin
      errors++;
      $display("FAIL wrap_next valid=%b pc=%h instr=%h want 1/0002/%h", valid, pc, instr, mem[0]);
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    fixed_lat = 1;
    mem[16'h0080] = 16'hF000;
    do_reset();
    tick(1'b0, 1'b1, 16'h0100);
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (valid !== 1'b1 || instr !== 16'hF000 || pc !== 16'h0102) begin
      errors++;
      $display("FAIL halt_deliver valid=%b instr=%h pc=%h want 1/f000/0102", valid, instr, pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      checks++;
      if (p_req !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_idle cyc=%0d req=%b valid=%b want 0/0", i, p_req, valid);
      end
    end
    tick(1'b0, 1'b1, 16'h0000);
    tick(1'b0, 1'b0, 16'h0);
    checks++;
    if (p_req !== 1'b1 || valid !== 1'b1 || pc !== 16'h0002) begin
      errors++;
      $display("FAIL halt_exit req=%b valid=%b pc=%h want 1/1/0002", p_req, valid, pc);
    end
  endtask
`endif

  // Random stall/flush/latency against an in-order instruction-stream model.
  task automatic test_random();
    logic [15:0] exp_next = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_pc = 16'h0000;
    logic        m_valid = 1'b0;
    logic        last_out = 1'b0;
    logic [15:0] last_addr = 16'h0000;
    int          delivered = 0;
    logic        s, f;
    logic [15:0] t;
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom % 4) == 0;
      f = ($urandom % 16) == 0;
      t = 16'($urandom);
      tick(s, f, t);
      if (last_out && p_req) begin
        checks++;
        if (p_addr !== last_addr) begin
          errors++;
          $display("FAIL rand_addr_stable cyc=%0d addr=%h want %h", i, p_addr, last_addr);
        end
      end
      last_out  = p_req && !p_mvalid;
      last_addr = p_addr;
      if (f) begin
        exp_next = t;
        m_valid  = 1'b0;
        m_instr  = NOP_INSTR;
      end else if (!s) begin
        if (valid) begin
          m_valid  = 1'b1;
          m_instr  = mem[exp_next[15:1]];
          m_pc     = exp_next + 16'd2;
          exp_next = exp_next + 16'd2;
          delivered++;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP_INSTR;
        end
      end
      checks++;
      if (valid !== m_valid || instr !== m_instr || (m_valid && pc !== m_pc)) begin
        errors++;
        $display("FAIL rand_out cyc=%0d s=%b f=%b valid=%b instr=%h pc=%h want %b/%h/%h",
                 i, s, f, valid, instr, pc, m_valid, m_instr, m_pc);
      end
    end
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL rand_throughput delivered=%0d want >= 50", delivered);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == OP_HLT) mem[i][15] = 1'b0;
    end
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
